// File: rtl/sv32_ptw_pkg.sv
// -----------------------------------------------------------------------------
// mmu_pkg: shared definitions for the Sv32 page-table walker.
//   - PA_WIDTH / VA_WIDTH : fixed Sv32 address widths
//   - PTE_* constants     : bit positions of the PTE permission bits
//   - pte_t               : packed view of a 32-bit Sv32 PTE
//   - ptw_state_e         : walker FSM states
// -----------------------------------------------------------------------------
package mmu_pkg;

  localparam int PA_WIDTH = 34;
  localparam int VA_WIDTH = 32;
  localparam int PPN_WIDTH = 22;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;

  typedef struct packed {
    logic [11:0] ppn1;
    logic [9:0]  ppn0;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    L1_REQ  = 3'd1,
    L1_WAIT = 3'd2,
    L0_REQ  = 3'd3,
    L0_WAIT = 3'd4,
    DONE    = 3'd5
  } ptw_state_e;

endpackage

// File: rtl/sv32_ptw_if.sv
// -----------------------------------------------------------------------------
// sv32_ptw_if: PTE read port between the walker and the memory system.
//   mem_req_valid/ready/addr : PTE read request (byte address)
//   mem_rsp_valid/data       : one response per accepted request, no backpressure
// Modports: master = walker side, slave = memory side.
// -----------------------------------------------------------------------------
interface sv32_ptw_if
  import mmu_pkg::*;
#(
  parameter int PA_WIDTH = mmu_pkg::PA_WIDTH
);

  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [PA_WIDTH-1:0] mem_req_addr;
  logic                mem_rsp_valid;
  logic [31:0]         mem_rsp_data;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data
  );

endinterface

// File: rtl/sv32_ptw_pte_check.sv
// -----------------------------------------------------------------------------
// pte_check: combinational classification of one Sv32 PTE.
//   pte        : PTE word under test
//   level      : 1 = first-level (superpage) lookup, 0 = second level
//   invalid    : V=0, or W=1 without R
//   leaf       : R or X set
//   misaligned : first-level leaf whose PPN[0] field is non-zero
// -----------------------------------------------------------------------------
module pte_check
  import mmu_pkg::*;
(
  input  pte_t pte,
  input  logic level,
  output logic invalid,
  output logic leaf,
  output logic misaligned
);

  logic [31:0] bits;
  logic        unused_bits;

  assign bits = pte;

  assign invalid    = ~bits[PTE_V] | (~bits[PTE_R] & bits[PTE_W]);
  assign leaf       = bits[PTE_R] | bits[PTE_X];
  assign misaligned = level & leaf & (pte.ppn0 != '0);

  // Remaining PTE fields do not affect classification.
  assign unused_bits = ^{pte.ppn1, pte.rsw, pte.d, pte.a, pte.g, pte.u};

endmodule

// File: rtl/sv32_ptw.sv
// -----------------------------------------------------------------------------
// sv32_ptw: two-level Sv32 hardware page-table walker.
//   i_clk, i_rstn        : clock, asynchronous active-low reset
//   satp_ppn             : root page-table PPN, captured when a VA is popped
//   fifo_empty/pop_data  : show-ahead request FIFO head; pop is a 1-cycle strobe
//   mem (master)         : PTE read request/response port
//   res_*                : translation result, held until res_ready
//   busy                 : walker not idle
// -----------------------------------------------------------------------------
module sv32_ptw
  import mmu_pkg::*;
#(
  parameter int PA_WIDTH = 34,  // only the Sv32 value is supported
  parameter int VA_WIDTH = 32   // only the Sv32 value is supported
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [21:0]         satp_ppn,
  input  logic                fifo_empty,
  input  logic [VA_WIDTH-1:0] pop_data,
  output logic                pop,
  sv32_ptw_if.master          mem,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [PA_WIDTH-1:0] res_paddr,
  output logic                res_fault,
  output logic [7:0]          res_flags,
  output logic                busy
);

  ptw_state_e          state_reg, state_next;
  logic [VA_WIDTH-1:0] va_reg, va_next;
  logic [21:0]         satp_reg, satp_next;
  logic [21:0]         l1_ppn_reg, l1_ppn_next;
  logic [PA_WIDTH-1:0] paddr_reg, paddr_next;
  logic                fault_reg, fault_next;
  logic [7:0]          flags_reg, flags_next;

  logic                req_valid;
  logic [PA_WIDTH-1:0] req_addr;

  pte_t rsp_pte;
  logic at_l1;
  logic chk_invalid, chk_leaf, chk_misaligned;

  assign rsp_pte = mem.mem_rsp_data;
  assign at_l1   = (state_reg == L1_WAIT);

  // One checker serves both levels; only the misalignment rule depends on level.
  pte_check u_pte_check (
    .pte        (rsp_pte),
    .level      (at_l1),
    .invalid    (chk_invalid),
    .leaf       (chk_leaf),
    .misaligned (chk_misaligned)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg  <= IDLE;
      va_reg     <= '0;
      satp_reg   <= '0;
      l1_ppn_reg <= '0;
      paddr_reg  <= '0;
      fault_reg  <= 1'b0;
      flags_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      va_reg     <= va_next;
      satp_reg   <= satp_next;
      l1_ppn_reg <= l1_ppn_next;
      paddr_reg  <= paddr_next;
      fault_reg  <= fault_next;
      flags_reg  <= flags_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    va_next     = va_reg;
    satp_next   = satp_reg;
    l1_ppn_next = l1_ppn_reg;
    paddr_next  = paddr_reg;
    fault_next  = fault_reg;
    flags_next  = flags_reg;
    pop         = 1'b0;
    req_valid   = 1'b0;
    req_addr    = '0;

    unique case (state_reg)
      IDLE: begin
        // pop is combinational from IDLE, so it is also gated by reset to keep
        // it low while i_rstn is asserted.
        if (!fifo_empty && i_rstn) begin
          pop        = 1'b1;
          va_next    = pop_data;
          satp_next  = satp_ppn;
          state_next = L1_REQ;
        end
      end
      L1_REQ: begin
        req_valid = 1'b1;
        req_addr  = {satp_reg, va_reg[31:22], 2'b00};
        if (mem.mem_req_ready) state_next = L1_WAIT;
      end
      L1_WAIT: begin
        if (mem.mem_rsp_valid) begin
          if (chk_invalid || chk_misaligned) begin
            fault_next = 1'b1;
            paddr_next = '0;
            flags_next = '0;
            state_next = DONE;
          end else if (chk_leaf) begin
            fault_next = 1'b0;
            paddr_next = {mem.mem_rsp_data[31:20], va_reg[21:0]};
            flags_next = mem.mem_rsp_data[7:0];
            state_next = DONE;
          end else begin
            l1_ppn_next = mem.mem_rsp_data[31:10];
            state_next  = L0_REQ;
          end
        end
      end
      L0_REQ: begin
        req_valid = 1'b1;
        req_addr  = {l1_ppn_reg, va_reg[21:12], 2'b00};
        if (mem.mem_req_ready) state_next = L0_WAIT;
      end
      L0_WAIT: begin
        if (mem.mem_rsp_valid) begin
          if (chk_invalid || !chk_leaf) begin
            fault_next = 1'b1;
            paddr_next = '0;
            flags_next = '0;
          end else begin
            fault_next = 1'b0;
            paddr_next = {mem.mem_rsp_data[31:10], va_reg[11:0]};
            flags_next = mem.mem_rsp_data[7:0];
          end
          state_next = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem.mem_req_valid = req_valid;
  assign mem.mem_req_addr  = req_addr;

  assign res_valid = (state_reg == DONE);
  assign res_paddr = paddr_reg;
  assign res_fault = fault_reg;
  assign res_flags = flags_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_sv32_ptw.sv
// -----------------------------------------------------------------------------
// tb_sv32_ptw: self-checking bench for sv32_ptw. Expected request addresses,
// results and latencies come from an arithmetic model of the Sv32 walk rules.
// -----------------------------------------------------------------------------
module tb_sv32_ptw;

  logic        clk;
  logic        rstn;
  logic [21:0] satp_ppn;
  logic        fifo_empty;
  logic [31:0] pop_data;
  logic        pop;
  logic        res_valid;
  logic        res_ready;
  logic [33:0] res_paddr;
  logic        res_fault;
  logic [7:0]  res_flags;
  logic        busy;

  sv32_ptw_if #(.PA_WIDTH(34)) mem_if ();

  sv32_ptw #(.PA_WIDTH(34), .VA_WIDTH(32)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .satp_ppn   (satp_ppn),
    .fifo_empty (fifo_empty),
    .pop_data   (pop_data),
    .pop        (pop),
    .mem        (mem_if),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_paddr  (res_paddr),
    .res_fault  (res_fault),
    .res_flags  (res_flags),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]  nreq;
    logic [33:0] a1;
    logic [33:0] a2;
    logic [33:0] paddr;
    logic        fault;
    logic [7:0]  flags;
  } exp_t;

  function automatic bit pte_bad(input logic [31:0] p);
    return !p[0] || (!p[1] && p[2]);
  endfunction

  function automatic bit pte_leaf(input logic [31:0] p);
    return p[1] || p[3];
  endfunction

  // Reference walk: addresses are page base * 4096 + index * 4 (PTE size).
  function automatic exp_t model(input logic [21:0] satp, input logic [31:0] va,
                                 input logic [31:0] l1, input logic [31:0] l0);
    exp_t e;
    e.nreq  = 2'd1;
    e.a1    = 34'(satp) * 34'd4096 + 34'(va[31:22]) * 34'd4;
    e.a2    = '0;
    e.paddr = '0;
    e.fault = 1'b0;
    e.flags = '0;
    if (pte_bad(l1)) begin
      e.fault = 1'b1;
    end else if (pte_leaf(l1)) begin
      if (l1[19:10] != 10'd0) begin
        e.fault = 1'b1;
      end else begin
        e.paddr = 34'(l1[31:20]) * 34'd4194304 + 34'(va[21:0]);
        e.flags = l1[7:0];
      end
    end else begin
      e.nreq = 2'd2;
      e.a2   = 34'(l1[31:10]) * 34'd4096 + 34'(va[21:12]) * 34'd4;
      if (pte_bad(l0) || !pte_leaf(l0)) begin
        e.fault = 1'b1;
      end else begin
        e.paddr = 34'(l0[31:10]) * 34'd4096 + 34'(va[11:0]);
        e.flags = l0[7:0];
      end
    end
    return e;
  endfunction

  // cat: 0 V=0, 1 W without R, 2 leaf with non-zero PPN[0], 3 aligned leaf, 4 pointer
  function automatic logic [31:0] gen_pte(input int cat);
    logic [31:0] p;
    p = $urandom;
    case (cat)
      0: p[0] = 1'b0;
      1: begin p[0] = 1'b1; p[1] = 1'b0; p[2] = 1'b1; end
      2: begin p[0] = 1'b1; p[1] = 1'b1; p[19:10] = 10'($urandom_range(1, 1023)); end
      3: begin
        p[0] = 1'b1;
        p[1] = 1'($urandom_range(0, 1));
        if (!p[1]) begin p[2] = 1'b0; p[3] = 1'b1; end
        p[19:10] = 10'd0;
      end
      default: begin p[0] = 1'b1; p[1] = 1'b0; p[2] = 1'b0; p[3] = 1'b0; end
    endcase
    return p;
  endfunction

  task automatic run_walk(input string name, input logic [21:0] satp, input logic [31:0] va,
                          input logic [31:0] l1, input logic [31:0] l0,
                          input int req_delay, input int res_delay);
    exp_t        e;
    int          reqs, waitc, lat, exp_lat;
    bit          done, rsp_pending;
    logic [31:0] rsp_word;
    e = model(satp, va, l1, l0);
    @(negedge clk);
    fifo_empty = 1'b0;
    pop_data = va;
    satp_ppn = satp;
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b0;
    res_ready = 1'b0;
    #1;
    check_eq({name, ".idle_busy"}, 64'(busy), 64'd0);
    check_eq({name, ".pop"}, 64'(pop), 64'd1);
    reqs = 0; waitc = 0; lat = -1; done = 0; rsp_pending = 0; rsp_word = '0;
    for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
      @(negedge clk);
      fifo_empty = 1'($urandom_range(0, 1));
      pop_data = $urandom;
      satp_ppn = 22'($urandom);
      mem_if.mem_req_ready = 1'b0;
      res_ready = 1'b0;
      // Stray response pulses land only in cycles where no response is due.
      mem_if.mem_rsp_valid = rsp_pending ? 1'b1 : ($urandom_range(0, 3) == 0);
      mem_if.mem_rsp_data = rsp_pending ? rsp_word : $urandom;
      rsp_pending = 0;
      #1;
      check_eq({name, ".busy"}, 64'(busy), 64'd1);
      check_eq({name, ".no_pop"}, 64'(pop), 64'd0);
      if (mem_if.mem_req_valid) begin
        if (reqs >= int'(e.nreq)) begin
          check_eq({name, ".req_count"}, 64'(reqs + 1), 64'(e.nreq));
        end else begin
          check_eq({name, ".req_addr"}, 64'(mem_if.mem_req_addr), 64'(reqs == 0 ? e.a1 : e.a2));
        end
        if (waitc == req_delay) begin
          mem_if.mem_req_ready = 1'b1;
          rsp_word = (reqs == 0) ? l1 : l0;
          reqs++;
          rsp_pending = 1;
          waitc = 0;
        end else begin
          waitc++;
        end
      end
      if (res_valid) begin
        if (lat < 0) lat = cyc;
        check_eq({name, ".paddr"}, 64'(res_paddr), 64'(e.paddr));
        check_eq({name, ".fault"}, 64'(res_fault), 64'(e.fault));
        check_eq({name, ".flags"}, 64'(res_flags), 64'(e.flags));
        if (waitc == res_delay) begin
          res_ready = 1'b1;
          done = 1;
        end else begin
          waitc++;
        end
      end
    end
    exp_lat = ((e.nreq == 2'd2) ? 5 : 3) + req_delay * int'(e.nreq);
    check_eq({name, ".done"}, 64'(done), 64'd1);
    check_eq({name, ".reqs"}, 64'(reqs), 64'(e.nreq));
    check_eq({name, ".latency"}, 64'(lat), 64'(exp_lat));
    $display("%s: satp=%h va=%h l1=%h l0=%h reqs=%0d lat=%0d paddr=%h fault=%0d flags=%h",
             name, satp, va, l1, l0, reqs, lat, e.paddr, e.fault, e.flags);
  endtask

  initial begin
    int c1;
    rstn = 1'b0;
    fifo_empty = 1'b0;
    pop_data = 32'h00401234;
    satp_ppn = 22'h080;
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b0;
    mem_if.mem_rsp_data = '0;
    res_ready = 1'b0;

    // Reset state, with a non-empty FIFO offered to confirm pop stays low.
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst.pop", 64'(pop), 64'd0);
    check_eq("rst.busy", 64'(busy), 64'd0);
    check_eq("rst.req_valid", 64'(mem_if.mem_req_valid), 64'd0);
    check_eq("rst.res_valid", 64'(res_valid), 64'd0);
    check_eq("rst.paddr", 64'(res_paddr), 64'd0);
    $display("reset: pop=%0d busy=%0d res_valid=%0d", pop, busy, res_valid);
    @(negedge clk);
    rstn = 1'b1;
    fifo_empty = 1'b1;

    run_walk("two_level", 22'h080, 32'h00401234, 32'h00024001, 32'h00028007, 0, 0);
    run_walk("superpage", 22'h080, 32'h00401234, 32'h0030000F, 32'h0, 0, 0);
    run_walk("misaligned", 22'h080, 32'h00401234, 32'h0000040F, 32'h0, 0, 0);
    run_walk("l1_zero", 22'h080, 32'h00401234, 32'h00000000, 32'h0, 0, 0);
    run_walk("stalled", 22'h080, 32'h00401234, 32'h00024001, 32'h00028007, 3, 2);
    run_walk("l0_pointer", 22'h3FFFFF, 32'hFFFFFFFF, 32'hFFFFFC01, 32'h00000001, 1, 0);

    // Empty FIFO: walker stays idle.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      fifo_empty = 1'b1;
      pop_data = $urandom;
      #1;
      check_eq("empty.pop", 64'(pop), 64'd0);
      check_eq("empty.busy", 64'(busy), 64'd0);
    end
    $display("empty_fifo: 10 idle cycles pop=%0d busy=%0d", pop, busy);

    // Reset while waiting for the second-level response.
    @(negedge clk);
    fifo_empty = 1'b0;
    pop_data = 32'h00401234;
    satp_ppn = 22'h080;
    #1;
    check_eq("abort.pop", 64'(pop), 64'd1);
    @(negedge clk);
    fifo_empty = 1'b1;
    mem_if.mem_req_ready = 1'b1;
    #1;
    check_eq("abort.l1_addr", 64'(mem_if.mem_req_addr), 64'h080004);
    @(negedge clk);
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b1;
    mem_if.mem_rsp_data = 32'h00024001;
    @(negedge clk);
    mem_if.mem_rsp_valid = 1'b0;
    mem_if.mem_req_ready = 1'b1;
    #1;
    check_eq("abort.l0_addr", 64'(mem_if.mem_req_addr), 64'h090004);
    @(negedge clk);
    mem_if.mem_req_ready = 1'b0;
    #1;
    check_eq("abort.l0_wait_busy", 64'(busy), 64'd1);
    rstn = 1'b0;
    #1;
    check_eq("abort.busy", 64'(busy), 64'd0);
    check_eq("abort.req_valid", 64'(mem_if.mem_req_valid), 64'd0);
    check_eq("abort.req_addr", 64'(mem_if.mem_req_addr), 64'd0);
    check_eq("abort.res_valid", 64'(res_valid), 64'd0);
    check_eq("abort.fault", 64'(res_fault), 64'd0);
    check_eq("abort.paddr", 64'(res_paddr), 64'd0);
    check_eq("abort.flags", 64'(res_flags), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    mem_if.mem_rsp_valid = 1'b1;
    mem_if.mem_rsp_data = 32'h00028007;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mem_if.mem_rsp_valid = 1'b0;
      #1;
      check_eq("stray.res_valid", 64'(res_valid), 64'd0);
      check_eq("stray.busy", 64'(busy), 64'd0);
    end
    $display("abort: reset in L0_WAIT, stray response ignored res_valid=%0d", res_valid);

    // Randomized walks; first-level PTEs are biased toward pointers.
    for (int i = 0; i < 40; i++) begin
      c1 = $urandom_range(0, 9);
      if (c1 > 4) c1 = (c1 < 7) ? 3 : 4;
      run_walk($sformatf("rnd%0d", i), 22'($urandom), $urandom, gen_pte(c1),
               gen_pte($urandom_range(0, 4)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sv32_ptw.md
SV32_PTW -- requirements
Module: sv32_ptw

Interface
REQ-001 Parameter: PA_WIDTH, 34, physical address width; fixed Sv32 value, no other value supported.
REQ-002 Parameter: VA_WIDTH, 32, virtual address width; fixed Sv32 value.
REQ-003 i_clk  input  1  clock; all state changes on rising edge.
REQ-004 i_rstn  input  1  reset, asynchronous, active-low.
REQ-005 satp_ppn  input  22  root page-table PPN; sampled in the pop cycle.
REQ-006 fifo_empty  input  1  upstream request FIFO empty flag.
REQ-007 pop_data  input  VA_WIDTH  head VA of the FIFO; show-ahead, valid whenever fifo_empty=0.
REQ-008 pop  output  1  single-cycle pop strobe to the FIFO.
REQ-009 mem_req_valid / mem_req_ready  output / input  1 / 1  PTE read request handshake.
REQ-010 mem_req_addr  output  PA_WIDTH  PTE byte address.
REQ-011 mem_rsp_valid / mem_rsp_data  input / input  1 / 32  read response, one per accepted request, no backpressure.
REQ-012 res_valid / res_ready  output / input  1 / 1  translation result handshake.
REQ-013 res_paddr  output  PA_WIDTH  translated address; 0 on fault.
REQ-014 res_fault  output  1  page fault flag.
REQ-015 res_flags  output  8  leaf PTE bits [7:0]; 0 on fault.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT and DONE.
REQ-018 IDLE with fifo_empty=0: pop=1 for exactly one cycle, VA and satp_ppn latched, next L1_REQ; with fifo_empty=1 pop stays 0.
REQ-019 L1_REQ: mem_req_valid=1, mem_req_addr={satp_ppn, VA[31:22], 2'b00}, held stable until mem_req_ready=1, then L1_WAIT.
REQ-020 mem_rsp_valid SHALL be ignored outside L1_WAIT/L0_WAIT.
REQ-021 PTE decode: V=bit0, R=bit1, W=bit2, X=bit3; invalid if V=0 or (R=0 and W=1); leaf if R=1 or X=1.
REQ-022 L1_WAIT response outcomes:
- invalid: fault, go to DONE.
- leaf with PTE[19:10]!=0: misaligned superpage, fault, go to DONE.
- leaf otherwise: res_paddr={PTE[31:20], VA[21:0]}, go to DONE.
- non-leaf: go to L0_REQ.
REQ-023 L0_REQ: mem_req_addr={PTE_L1[31:10], VA[21:12], 2'b00}, same handshake as L1_REQ, then L0_WAIT.
REQ-024 L0_WAIT response outcomes:
- invalid or non-leaf: fault.
- otherwise: res_paddr={PTE[31:10], VA[11:0]}.
- either case: go to DONE.
REQ-025 DONE: res_valid=1 with res_paddr/res_fault/res_flags held stable until res_ready=1, then IDLE; no pop in that same cycle.
REQ-026 Minimum latency with ready/response in the next cycle: pop at cycle 0; result valid at cycle 5 for a two-level walk and cycle 3 for a superpage.
REQ-027 Exactly one memory request per level and one pop per result.
REQ-028 Address concatenations SHALL be zero-extended to PA_WIDTH with no arithmetic carry.

Reset
REQ-029 Asserting i_rstn low SHALL force IDLE immediately and drive pop, mem_req_valid, res_valid, busy, res_fault to 0 and mem_req_addr, res_paddr, res_flags to 0.
REQ-030 Reset mid-walk SHALL abandon the walk; a late mem_rsp_valid after reset SHALL be ignored.
REQ-031 The first pop after reset release occurs no earlier than the first rising edge with i_rstn high.

Structure
REQ-032 mmu_pkg SHALL hold the FSM state enum, pte_t typedef, PTE bit-position constants, and PA_WIDTH/VA_WIDTH constants.
REQ-033 Combinational sub-module pte_check (inputs PTE and level; outputs invalid, leaf, misaligned) SHALL be used for both levels.

Verification
REQ-034 satp_ppn=0x080, VA=0x00401234, L1 PTE 0x00024001, L0 PTE 0x00028007 -> requests 0x080004 then 0x090004; res_paddr=0x0A0234, res_flags=0x07, fault=0.
REQ-035 Same VA, L1 PTE 0x0030000F -> single request; res_paddr=0x00C01234, fault=0.
REQ-036 L1 PTE 0x0000040F -> fault=1, res_paddr=0; L1 PTE 0x00000000 -> fault=1 after one request.
REQ-037 mem_req_ready low 3 cycles and res_ready low 2 cycles -> address and result stable throughout; one request and one pop per walk.
REQ-038 fifo_empty=1 for 10 cycles -> pop=0 and busy=0 throughout; reset asserted in L0_WAIT -> IDLE with outputs 0, and a subsequent stray response produces no result.
